chan_mux_arb: RTL and testbench

CHAN_MUX_ARB -- requirements
Module: chan_mux_arb

---
 rtl/chan_mux_pkg.sv | 7 +
 rtl/chan_mux_arb_rr_pick.sv | 26 ++
 rtl/chan_mux_arb.sv | 100 ++++++++++
 tb/tb_chan_mux_arb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/chan_mux_pkg.sv
// Shared constants for the channel multiplexer/arbiter.
package chan_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/chan_mux_arb_rr_pick.sv
// Rotating-priority search: first requester at or above ptr, wrapping at NCH-1.
module rr_pick #(
  parameter int NCH  = 2,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  int w_j;

  // Walk the channels starting at ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    w_j   = 0;
    for (int k = 0; k < NCH; k++) begin
      w_j   = (int'(ptr) + k) % NCH;
      idx   = (~found & req[w_j]) ? SELW'(w_j) : idx;
      found = found | req[w_j];
    end
  end

endmodule

// File: rtl/chan_mux_arb.sv
// Multi-channel mux with fixed/round-robin arbitration into a one-entry output register.
module chan_mux_arb
  import chan_mux_pkg::*;
#(
  parameter int W    = 4,
  parameter int NCH  = 2,
  parameter int SELW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SELW-1:0]  sel,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  output logic [NCH-1:0]   in_ready,
  output logic [W-1:0]     out_data,
  output logic [SELW-1:0]  out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [SELW:0] NCH_L = NCH[SELW:0];

  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_out_chan;
  logic [SELW-1:0] r_ptr;

  logic            w_load_en;
  logic            w_rr_found;
  logic [SELW-1:0] w_rr_idx;
  logic            w_has_cand;
  logic [SELW-1:0] w_cand;
  logic            w_cand_valid;
  logic [W-1:0]    w_cand_data;
  logic            w_grant;
  logic [NCH-1:0]  w_ready;

  assign w_load_en = ~r_out_valid | out_ready;

  rr_pick #(.NCH(NCH), .SELW(SELW)) u_rr_pick (
    .req   (in_valid),
    .ptr   (r_ptr),
    .found (w_rr_found),
    .idx   (w_rr_idx)
  );

  // Candidate channel: rotating search in RR mode, sel (when in range) in fixed mode.
  always_comb begin
    w_has_cand = 1'b0;
    w_cand     = '0;
    if (mode == MODE_RR) begin
      w_has_cand = w_rr_found;
      w_cand     = w_rr_idx;
    end else begin
      w_has_cand = ({1'b0, sel} < NCH_L);
      w_cand     = sel;
    end
  end

  // Route the candidate's data/valid and form the one-hot accept strobe.
  always_comb begin
    w_cand_valid = 1'b0;
    w_cand_data  = '0;
    for (int i = 0; i < NCH; i++) begin
      w_cand_valid = (SELW'(i) == w_cand) ? in_valid[i] : w_cand_valid;
      w_cand_data  = (SELW'(i) == w_cand) ? in_data[i*W +: W] : w_cand_data;
    end
    w_grant = ~rst & w_load_en & w_has_cand & w_cand_valid;
    w_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      w_ready[i] = w_grant & (SELW'(i) == w_cand);
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_ptr       <= '0;
    end else if (w_grant) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_cand_data;
      r_out_chan  <= w_cand;
      if (mode == MODE_RR) begin
        r_ptr <= ({1'b0, w_cand} == NCH_L - (SELW+1)'(1)) ? '0 : w_cand + SELW'(1);
      end
    end else if (w_load_en) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_ready;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_chan_mux_arb.sv
// Self-checking bench: a 4-channel and a 3-channel instance share stimulus against a behavioural model.
module tb_chan_mux_arb;

  logic        clk = 1'b0;
  logic        rst, mode, out_ready;
  logic [1:0]  sel4, sel3;
  logic [15:0] in_data;
  logic [3:0]  in_valid;

  logic [3:0]  rdy4;
  logic [3:0]  od4;
  logic [1:0]  oc4;
  logic        ov4;
  logic [2:0]  rdy3;
  logic [3:0]  od3;
  logic [1:0]  oc3;
  logic        ov3;

  int errors = 0;
  int checks = 0;

  // Model state per instance: index 0 = NCH 4, index 1 = NCH 3.
  logic       m_v [2];
  logic [3:0] m_d [2];
  logic [1:0] m_c [2];
  int         m_p [2];
  logic [3:0] e_rdy [2];
  logic [3:0] seen_rdy [2];

  always #5 clk = ~clk;

  chan_mux_arb #(.W(4), .NCH(4)) u_dut4 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel4),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy4),
    .out_data(od4), .out_chan(oc4), .out_valid(ov4), .out_ready(out_ready)
  );

  chan_mux_arb #(.W(4), .NCH(3)) u_dut3 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel3),
    .in_data(in_data[11:0]), .in_valid(in_valid[2:0]), .in_ready(rdy3),
    .out_data(od3), .out_chan(oc3), .out_valid(ov3), .out_ready(out_ready)
  );

  // Which channel the arbitration rules would offer, or -1 when none.
  function automatic int pick(int nch, logic md, int s, int p, logic [3:0] v);
    int j;
    if (md == 1'b0) return (s < nch && v[s]) ? s : -1;
    for (int k = 0; k < nch; k++) begin
      j = (p + k) % nch;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Sample in_ready mid-cycle, advance the model, then step past the clock edge.
  task automatic tick();
    int  nch, s, c;
    bit  load;
    #2;
    seen_rdy[0] = rdy4;
    seen_rdy[1] = {1'b0, rdy3};
    for (int d = 0; d < 2; d++) begin
      nch  = (d == 0) ? 4 : 3;
      s    = (d == 0) ? int'(sel4) : int'(sel3);
      c    = pick(nch, mode, s, m_p[d], in_valid);
      load = !m_v[d] || out_ready;
      if (rst) begin
        e_rdy[d] = 4'h0; m_v[d] = 1'b0; m_d[d] = 4'h0; m_c[d] = 2'd0; m_p[d] = 0;
      end else if (load && c >= 0) begin
        e_rdy[d] = 4'(1 << c);
        m_v[d]   = 1'b1;
        m_d[d]   = 4'((in_data >> (4 * c)) & 16'hF);
        m_c[d]   = 2'(c);
        if (mode) m_p[d] = (c + 1) % nch;
      end else begin
        e_rdy[d] = 4'h0;
        if (load) m_v[d] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1; in_data = 16'(($urandom));
    tick();
    checks++; if (seen_rdy[0] !== 4'h0) begin errors++; $display("FAIL reset_rdy4 got %b want 0000", seen_rdy[0]); end
    checks++; if (seen_rdy[1] !== 4'h0) begin errors++; $display("FAIL reset_rdy3 got %b want 0000", seen_rdy[1]); end
    checks++; if ({ov4, od4, oc4} !== 7'd0) begin errors++; $display("FAIL reset_out4 got v%b d%h c%0d want all 0", ov4, od4, oc4); end
    checks++; if ({ov3, od3, oc3} !== 7'd0) begin errors++; $display("FAIL reset_out3 got v%b d%h c%0d want all 0", ov3, od3, oc3); end
    rst = 1'b0;
  endtask

  task automatic test_fixed();
    mode = 1'b0; sel4 = 2'd1; sel3 = 2'd1; in_valid = 4'b0011; in_data = 16'h00A3; out_ready = 1'b1;
    tick();
    checks++; if (seen_rdy[0] !== 4'b0010) begin errors++; $display("FAIL fixed_rdy got %b want 0010", seen_rdy[0]); end
    checks++; if ({ov4, od4, oc4} !== {1'b1, 4'hA, 2'd1}) begin errors++; $display("FAIL fixed_out got v%b d%h c%0d want v1 dA c1", ov4, od4, oc4); end
  endtask

  task automatic test_backpressure();
    sel4 = 2'd0; in_data = 16'h0005; in_valid = 4'b0001; out_ready = 1'b1;
    tick();
    checks++; if (od4 !== 4'h5) begin errors++; $display("FAIL bp_first got %h want 5", od4); end
    out_ready = 1'b0; in_data = 16'h0007;
    for (int i = 0; i < 3; i++) begin
      sel4 = 2'(i + 1);
      tick();
      checks++; if (seen_rdy[0] !== 4'h0) begin errors++; $display("FAIL bp_rdy cyc%0d got %b want 0000", i, seen_rdy[0]); end
      checks++; if ({ov4, od4, oc4} !== {1'b1, 4'h5, 2'd0}) begin errors++; $display("FAIL bp_hold cyc%0d got v%b d%h c%0d want v1 d5 c0", i, ov4, od4, oc4); end
    end
    sel4 = 2'd0; out_ready = 1'b1;
    tick();
    checks++; if (seen_rdy[0] !== 4'b0001) begin errors++; $display("FAIL bp_release_rdy got %b want 0001", seen_rdy[0]); end
    checks++; if (od4 !== 4'h7) begin errors++; $display("FAIL bp_release_data got %h want 7", od4); end
    in_valid = 4'h0;
    tick();
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", ov4); end
  endtask

  task automatic test_rr_seq();
    logic [3:0] want;
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 16'($urandom);
      want = 4'((in_data >> (4 * (i % 4))) & 16'hF);
      tick();
      checks++; if ({ov4, oc4, od4} !== {1'b1, 2'(i % 4), want}) begin errors++; $display("FAIL rr_seq cyc%0d got v%b c%0d d%h want v1 c%0d d%h", i, ov4, oc4, od4, i % 4, want); end
    end
  endtask

  task automatic test_rr_wrap();
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0100;
    tick();
    checks++; if (oc4 !== 2'd2) begin errors++; $display("FAIL rr_setup got c%0d want c2", oc4); end
    in_valid = 4'b0010;
    tick();
    checks++; if (seen_rdy[0] !== 4'b0010 || oc4 !== 2'd1) begin errors++; $display("FAIL rr_wrap got rdy %b c%0d want 0010 c1", seen_rdy[0], oc4); end
    in_valid = 4'hF;
    tick();
    checks++; if (oc4 !== 2'd2) begin errors++; $display("FAIL rr_ptr_after_wrap got c%0d want c2", oc4); end
  endtask

  task automatic test_sel_oob();
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 1'b0; sel3 = 2'd0; in_valid = 4'hF; out_ready = 1'b0;
    tick();
    checks++; if (ov3 !== 1'b1) begin errors++; $display("FAIL oob_load got v%b want 1", ov3); end
    sel3 = 2'd3;
    tick();
    checks++; if (seen_rdy[1] !== 4'h0 || ov3 !== 1'b1) begin errors++; $display("FAIL oob_hold got rdy %b v%b want 000 v1", seen_rdy[1], ov3); end
    out_ready = 1'b1;
    tick();
    checks++; if (seen_rdy[1] !== 4'h0 || ov3 !== 1'b0) begin errors++; $display("FAIL oob_drain got rdy %b v%b want 000 v0", seen_rdy[1], ov3); end
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1; in_data = 16'h9876;
    tick();
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (seen_rdy[0] !== 4'h0) begin errors++; $display("FAIL midrst_rdy got %b want 0000", seen_rdy[0]); end
    checks++; if ({ov4, od4, oc4} !== 7'd0) begin errors++; $display("FAIL midrst_out got v%b d%h c%0d want all 0", ov4, od4, oc4); end
    rst = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if ({ov4, oc4, od4} !== {1'b1, 2'd0, 4'h6}) begin errors++; $display("FAIL midrst_first_grant got v%b c%0d d%h want v1 c0 d6", ov4, oc4, od4); end
  endtask

  task automatic test_random();
    logic       a_v;
    logic [3:0] a_d;
    logic [1:0] a_c;
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 40) == 0);
      mode      = 1'($urandom);
      sel4      = 2'($urandom);
      sel3      = 2'($urandom);
      in_valid  = 4'($urandom);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      for (int d = 0; d < 2; d++) begin
        a_v = (d == 0) ? ov4 : ov3;
        a_d = (d == 0) ? od4 : od3;
        a_c = (d == 0) ? oc4 : oc3;
        checks++; if (seen_rdy[d] !== e_rdy[d]) begin errors++; $display("FAIL rand_rdy dut%0d cyc%0d got %b want %b", d, n, seen_rdy[d], e_rdy[d]); end
        checks++; if (a_v !== m_v[d]) begin errors++; $display("FAIL rand_valid dut%0d cyc%0d got %b want %b", d, n, a_v, m_v[d]); end
        if (m_v[d]) begin
          checks++; if ({a_d, a_c} !== {m_d[d], m_c[d]}) begin errors++; $display("FAIL rand_word dut%0d cyc%0d got d%h c%0d want d%h c%0d", d, n, a_d, a_c, m_d[d], m_c[d]); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel4 = 2'd0; sel3 = 2'd0;
    in_data = 16'h0; in_valid = 4'h0; out_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_v[d] = 1'b0; m_d[d] = 4'h0; m_c[d] = 2'd0; m_p[d] = 0; e_rdy[d] = 4'h0; seen_rdy[d] = 4'h0;
    end
    test_reset();
    test_fixed();
    test_backpressure();
    test_rr_seq();
    test_rr_wrap();
    test_sel_oob();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
